// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending controller: state encoding and
// default parameter values.
package vend_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PAY      = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_PRODUCTS = 8;
    localparam int unsigned DEF_PRICE_W      = 8;
    localparam int unsigned DEF_STOCK_W      = 4;
    localparam int unsigned DEF_TIMEOUT_CYC  = 1000;

endpackage

// File: rtl/vend_product_table.sv
// Per-slot price and stock registers: one write port, one combinational read
// port with range check, and a stock decrement port that stops at zero.
module vend_product_table
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PRODUCTS = DEF_NUM_PRODUCTS,
    parameter int unsigned PRICE_W      = DEF_PRICE_W,
    parameter int unsigned STOCK_W      = DEF_STOCK_W,
    localparam int unsigned IDX_W       = $clog2(NUM_PRODUCTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [PRICE_W-1:0] wr_price,
    input  logic [STOCK_W-1:0] wr_stock,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid_c,
    output logic [PRICE_W-1:0] rd_price_c,
    output logic [STOCK_W-1:0] rd_stock_c,
    input  logic               dec_en,
    input  logic [IDX_W-1:0]   dec_idx
);

    localparam logic [IDX_W:0] NUM_P = (IDX_W+1)'(NUM_PRODUCTS);

    logic [PRICE_W-1:0] price_mem [NUM_PRODUCTS];
    logic [STOCK_W-1:0] stock_mem [NUM_PRODUCTS];

    logic wr_ok;
    logic dec_ok;

    always_comb begin
        rd_valid_c = ({1'b0, rd_idx} < NUM_P);
        wr_ok      = ({1'b0, wr_idx} < NUM_P);
        dec_ok     = ({1'b0, dec_idx} < NUM_P);
        rd_price_c = rd_valid_c ? price_mem[rd_idx] : '0;
        rd_stock_c = rd_valid_c ? stock_mem[rd_idx] : '0;
    end

    // Writes and decrements never coincide: writes happen only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_PRODUCTS); i++) begin
                price_mem[i] <= '0;
                stock_mem[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            price_mem[wr_idx] <= wr_price;
            stock_mem[wr_idx] <= wr_stock;
        end else if (dec_en && dec_ok && (stock_mem[dec_idx] != '0)) begin
            stock_mem[dec_idx] <= stock_mem[dec_idx] - STOCK_W'(1);
        end
    end

endmodule

// File: rtl/vend_engine.sv
// Vending controller: transaction FSM, saturating coin credit, inactivity
// timeout and registered dispense/change outputs around the product table.
module vend_engine
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PRODUCTS = DEF_NUM_PRODUCTS,
    parameter int unsigned PRICE_W      = DEF_PRICE_W,
    parameter int unsigned STOCK_W      = DEF_STOCK_W,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    localparam int unsigned IDX_W       = $clog2(NUM_PRODUCTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PRICE_W-1:0] cfg_price,
    input  logic [STOCK_W-1:0] cfg_stock,
    input  logic               start,
    input  logic               abort,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    input  logic               coin_valid,
    input  logic [PRICE_W-1:0] coin_value,
    input  logic               pay_online,
    output logic [2:0]         state,
    output logic [PRICE_W:0]   credit,
    output logic [PRICE_W-1:0] price_out,
    output logic               dispense,
    output logic [IDX_W-1:0]   dispense_idx,
    output logic               change_valid,
    output logic [PRICE_W:0]   change_amt,
    output logic               err_sold_out,
    output logic               err_invalid,
    output logic               timeout
);

    localparam int unsigned     CW         = PRICE_W + 1;
    localparam int unsigned     TMR_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_nxt;
    logic [CW-1:0]      credit_q, credit_nxt, credit_sum, chg_nxt;
    logic [CW:0]        sum_w;
    logic [PRICE_W-1:0] coin_add, price_nxt;
    logic [IDX_W-1:0]   slot_q, slot_nxt;
    logic [TMR_W-1:0]   tmr_q, tmr_nxt;
    logic               disp_nxt, chg_valid_nxt, err_so_nxt, err_inv_nxt, to_nxt;
    logic               activity, expired, dec_en_c, tbl_we_c;
    logic               tbl_ok_c;
    logic [PRICE_W-1:0] tbl_price_c;
    logic [STOCK_W-1:0] tbl_stock_c;

    assign tbl_we_c     = cfg_we && (state_q == ST_IDLE);
    assign state        = state_q;
    assign credit       = credit_q;
    assign dispense_idx = slot_q;

    vend_product_table #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .PRICE_W      (PRICE_W),
        .STOCK_W      (STOCK_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (tbl_we_c),
        .wr_idx     (cfg_idx),
        .wr_price   (cfg_price),
        .wr_stock   (cfg_stock),
        .rd_idx     (sel_idx),
        .rd_valid_c (tbl_ok_c),
        .rd_price_c (tbl_price_c),
        .rd_stock_c (tbl_stock_c),
        .dec_en     (dec_en_c),
        .dec_idx    (slot_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            price_out    <= '0;
            slot_q       <= '0;
            change_amt   <= '0;
            tmr_q        <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            err_sold_out <= 1'b0;
            err_invalid  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            credit_q     <= credit_nxt;
            price_out    <= price_nxt;
            slot_q       <= slot_nxt;
            change_amt   <= chg_nxt;
            tmr_q        <= tmr_nxt;
            dispense     <= disp_nxt;
            change_valid <= chg_valid_nxt;
            err_sold_out <= err_so_nxt;
            err_invalid  <= err_inv_nxt;
            timeout      <= to_nxt;
        end
    end

    // Next-state and registered-output decode; the same-cycle coin always
    // counts toward both the payment check and any refund.
    always_comb begin
        state_nxt     = state_q;
        credit_nxt    = credit_q;
        price_nxt     = price_out;
        slot_nxt      = slot_q;
        chg_nxt       = change_amt;
        tmr_nxt       = tmr_q;
        disp_nxt      = 1'b0;
        chg_valid_nxt = 1'b0;
        err_so_nxt    = 1'b0;
        err_inv_nxt   = 1'b0;
        to_nxt        = 1'b0;
        dec_en_c      = 1'b0;

        coin_add   = coin_valid ? coin_value : '0;
        sum_w      = {1'b0, credit_q} + (CW+1)'(coin_add);
        credit_sum = sum_w[CW] ? '1 : sum_w[CW-1:0];
        activity   = coin_valid || sel_valid;
        expired    = (tmr_q == '0) && !activity;

        if ((state_q == ST_SELECT) || (state_q == ST_PAY)) begin
            credit_nxt = credit_sum;
            if (activity) begin
                tmr_nxt = TMR_RELOAD;
            end else if (tmr_q != '0) begin
                tmr_nxt = tmr_q - TMR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SELECT;
                    tmr_nxt   = TMR_RELOAD;
                end
            end
            ST_SELECT: begin
                if (abort || expired) begin
                    state_nxt     = ST_CHANGE;
                    chg_nxt       = credit_sum;
                    chg_valid_nxt = 1'b1;
                    to_nxt        = !abort;
                end else if (sel_valid) begin
                    if (!tbl_ok_c) begin
                        err_inv_nxt = 1'b1;
                    end else if (tbl_stock_c == '0) begin
                        err_so_nxt = 1'b1;
                    end else begin
                        slot_nxt  = sel_idx;
                        price_nxt = tbl_price_c;
                        state_nxt = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (abort || expired) begin
                    state_nxt     = ST_CHANGE;
                    chg_nxt       = credit_sum;
                    chg_valid_nxt = 1'b1;
                    to_nxt        = !abort;
                    price_nxt     = '0;
                end else if (pay_online) begin
                    state_nxt = ST_DISPENSE;
                    disp_nxt  = 1'b1;
                    chg_nxt   = credit_sum;
                end else if (credit_sum >= CW'(price_out)) begin
                    state_nxt = ST_DISPENSE;
                    disp_nxt  = 1'b1;
                    chg_nxt   = credit_sum - CW'(price_out);
                end
            end
            ST_DISPENSE: begin
                dec_en_c      = 1'b1;
                state_nxt     = ST_CHANGE;
                chg_valid_nxt = 1'b1;
                price_nxt     = '0;
            end
            ST_CHANGE: begin
                credit_nxt = '0;
                state_nxt  = ST_IDLE;
            end
            default: begin
                credit_nxt = '0;
                price_nxt  = '0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

endmodule
